// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// slave = buffer side, master = fetch/decode side.
interface if_id_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_bus;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adef;
  logic [1:0]  count;

  modport slave (
    input  in_valid, in_bus, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_adef, count
  );

  modport master (
    output in_valid, in_bus, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_adef, count
  );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID FIFO of {PC, Inst}; flushed by branch/exception/ertn; `IFBUF_ADEF_CHECK_EN adds the ADEF flag.
// Latency: one cycle push-to-visible, no bypass; one packet per cycle when streaming.
// Backpressure: in_ready drops only when both entries are full, independent of out_ready.
module if_id_buffer #(
  parameter logic [31:0] RESET_INST = 32'h0340_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          excp_flush,
  input  logic          ertn_flush,
  if_id_buffer_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] entry [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic        any_flush;
  logic        in_ready_i;
  logic        out_valid_i;
  logic        push;
  logic        pop;
  logic [63:0] head;

  assign any_flush   = flush | excp_flush | ertn_flush;
  assign in_ready_i  = (state != FULL);
  assign out_valid_i = (state != EMPTY);
  assign push        = bus.in_valid & in_ready_i;
  assign pop         = out_valid_i & bus.out_ready;
  assign head        = entry[rd_ptr];

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_i;
  assign bus.out_pc    = head[63:32];
  assign bus.count     = state;

`ifdef IFBUF_ADEF_CHECK_EN
  logic adef;
  // A misaligned PC reaches decode as a NOP tagged with ADEF.
  assign adef         = out_valid_i & (head[33:32] != 2'b00);
  assign bus.out_adef = adef;
  assign bus.out_inst = adef ? RESET_INST : head[31:0];
`else
  assign bus.out_adef = 1'b0;
  assign bus.out_inst = head[31:0];
`endif

  always_ff @(posedge clk) begin
    if (reset || any_flush) begin
      state  <= EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        entry[i] <= {32'h0, RESET_INST};
      end
    end else begin
      if (push) begin
        entry[wr_ptr] <= bus.in_bus;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case (state)
        EMPTY:   if (push) state <= ONE;
        ONE: begin
          if (push && !pop)      state <= FULL;
          else if (pop && !push) state <= EMPTY;
        end
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end
endmodule
